subt_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one external 32-bit subtractor instance (Y = A − B) among N_REQ requesters in the arithmetic datapath. It accepts operand pairs over per-requester valid/ready handshakes and drives the shared subtractor's operand buses from registered operands. It then returns the difference, an unsigned-borrow flag and the requester ID over a single valid/ready result channel. Only one subtraction is in flight at a time.

---
 rtl/subt_rr_scheduler.sv | 81 ++++++++
 tb/tb_subt_rr_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/subt_rr_scheduler.sv
// subt_rr_scheduler: round-robin sharing of one external W-bit subtractor among N_REQ requesters.
// Ports: clk/rst_n (async active-low); req_valid/req_a/req_b/req_ready per-requester operand handshake;
// sub_a/sub_b/sub_y to and from the shared subtractor; res_valid/res_data/res_borrow/res_id/res_ready result channel.
module subt_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       sub_a,
  output logic [W-1:0]       sub_b,
  input  logic [W-1:0]       sub_y,
  output logic               res_valid,
  output logic [W-1:0]       res_data,
  output logic               res_borrow,
  output logic [ID_W-1:0]    res_id,
  input  logic               res_ready
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [ID_W-1:0] last_grant, id_r, winner;
  logic [W-1:0] op_a, op_b;
  logic found;
  int idx;
  // search starts one past the last grant and wraps, so the first hit is the fair winner
  always_comb begin
    winner = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end
  assign req_ready = (rst_n && state == IDLE && found) ? (N_REQ'(1) << winner) : '0;
  assign sub_a = op_a;
  assign sub_b = op_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      id_r <= '0;
      op_a <= '0;
      op_b <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_borrow <= 1'b0;
      res_id <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          op_a <= req_a[int'(winner)*W +: W];
          op_b <= req_b[int'(winner)*W +: W];
          id_r <= winner;
          last_grant <= winner;
          state <= EXEC;
        end
        EXEC: begin
          res_data <= sub_y;
          res_borrow <= op_a < op_b;
          res_id <= id_r;
          res_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_subt_rr_scheduler.sv
// tb_subt_rr_scheduler: table vectors plus scoreboarded sequences for the round-robin subtractor scheduler.
module tb_subt_rr_scheduler;
  logic clk, rst_n, res_ready, res_valid, res_borrow;
  logic [3:0] req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0] sub_a, sub_b, sub_y, res_data;
  logic [1:0] res_id;
  int compared, mismatched, cyc;

  typedef struct packed {
    logic [3:0] valid;
    logic [127:0] a;
    logic [127:0] b;
    logic [3:0] rdy;
    logic [31:0] data;
    logic borrow;
    logic [1:0] id;
  } vec_t;
  typedef struct packed {
    logic [1:0] id;
    logic [31:0] data;
    logic borrow;
  } exp_t;
  vec_t vec [7];
  exp_t q [$];

  subt_rr_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .sub_a(sub_a), .sub_b(sub_b), .sub_y(sub_y),
    .res_valid(res_valid), .res_data(res_data), .res_borrow(res_borrow),
    .res_id(res_id), .res_ready(res_ready)
  );

  assign sub_y = sub_a - sub_b;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int id, logic [31:0] a, logic [31:0] b);
    q.push_back('{id: 2'(id), data: a - b, borrow: a < b});
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    check("drain", 64'(q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) check("unexpected_result", 64'(res_id), 64'hx);
      else begin
        exp_t e;
        e = q.pop_front();
        check("res_id", 64'(res_id), 64'(e.id));
        check("res_data", 64'(res_data), 64'(e.data));
        check("res_borrow", 64'(res_borrow), 64'(e.borrow));
      end
    end
  end

  task automatic run_vec(vec_t v);
    req_valid = v.valid;
    req_a = v.a;
    req_b = v.b;
    #1;
    check("vec_ready", 64'(req_ready), 64'(v.rdy));
    q.push_back('{id: v.id, data: v.data, borrow: v.borrow});
    tick();
    req_valid = 0;
    check("vec_exec_valid", 64'(res_valid), 0);
    check("vec_sub_a", 64'(sub_a), 64'(v.a[int'(v.id)*32 +: 32]));
    check("vec_sub_b", 64'(sub_b), 64'(v.b[int'(v.id)*32 +: 32]));
    tick();
    check("vec_done_valid", 64'(res_valid), 1);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 0;
    q.delete();
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  initial begin
    int n, last_cyc;
    compared = 0;
    mismatched = 0;
    cyc = 0;
    rst_n = 0;
    res_ready = 1;
    req_valid = 0;
    req_a = '0;
    req_b = '0;
    vec[0] = '{4'b0100, {32'h0, 32'h10, 32'h0, 32'h0}, {32'h0, 32'h3, 32'h0, 32'h0}, 4'b0100, 32'h0000000D, 1'b0, 2'd2};
    vec[1] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0, 32'h1}, 4'b0001, 32'hFFFFFFFF, 1'b1, 2'd0};
    vec[2] = '{4'b1010, {32'h7, 32'h0, 32'h5, 32'h0}, {32'h2, 32'h0, 32'h5, 32'h0}, 4'b0010, 32'h00000000, 1'b0, 2'd1};
    vec[3] = '{4'b0011, {32'h0, 32'h0, 32'h9, 32'h80000000}, {32'h0, 32'h0, 32'h1, 32'h1}, 4'b0001, 32'h7FFFFFFF, 1'b0, 2'd0};
    vec[4] = '{4'b1111, {32'h1, 32'h2, 32'h1, 32'h3}, {32'h0, 32'h0, 32'h80000000, 32'h0}, 4'b0010, 32'h80000001, 1'b1, 2'd1};
    vec[5] = '{4'b1000, {32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, {32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, 4'b1000, 32'h00000000, 1'b0, 2'd3};
    vec[6] = '{4'b1001, {32'h5, 32'h0, 32'h0, 32'h12345678}, {32'h6, 32'h0, 32'h0, 32'h78}, 4'b0001, 32'h12345600, 1'b0, 2'd0};
    do_reset();
    check("rst_res_valid", 64'(res_valid), 0);
    check("rst_res_data", 64'(res_data), 0);
    check("rst_res_borrow", 64'(res_borrow), 0);
    check("rst_res_id", 64'(res_id), 0);
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_sub_a", 64'(sub_a), 0);
    check("rst_sub_b", 64'(sub_b), 0);
    foreach (vec[i]) run_vec(vec[i]);
    // fairness: all valid, res_ready held high
    do_reset();
    req_a = {32'd103, 32'd102, 32'd101, 32'd100};
    req_b = {32'd30, 32'd20, 32'd10, 32'd0};
    req_valid = 4'b1111;
    #1;
    last_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (req_ready == 0 && n < 8) begin
        tick();
        n++;
      end
      check("fair_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) check("fair_gap", 64'(cyc - last_cyc), 3);
      last_cyc = cyc;
      push(k % 4, req_a[(k % 4)*32 +: 32], req_b[(k % 4)*32 +: 32]);
      tick();
    end
    req_valid = 0;
    drain();
    // back-pressure: last grant was 1, so requester 0 alone wins
    res_ready = 0;
    req_a = {32'd9, 32'd8, 32'd77, 32'd50};
    req_b = {32'd1, 32'd1, 32'd100, 32'd8};
    req_valid = 4'b0001;
    #1;
    check("bp_ready", 64'(req_ready), 1);
    push(0, 32'd50, 32'd8);
    tick();
    req_valid = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(res_valid), 1);
      check("bp_data", 64'(res_data), 42);
      check("bp_id", 64'(res_id), 0);
      check("bp_req_ready", 64'(req_ready), 0);
      tick();
    end
    res_ready = 1;
    tick();
    check("bp_release", 64'(res_valid), 0);
    check("bp_next_ready", 64'(req_ready), 64'(4'b0010));
    push(1, 32'd77, 32'd100);
    tick();
    req_valid = 0;
    drain();
    // reset during EXEC discards the in-flight result
    req_valid = 4'b1001;
    #1;
    check("mid_ready", 64'(req_ready), 64'(4'b1000));
    push(3, 32'd9, 32'd1);
    tick();
    rst_n = 0;
    #1;
    check("mid_rst_valid", 64'(res_valid), 0);
    check("mid_rst_ready", 64'(req_ready), 0);
    check("mid_rst_sub_a", 64'(sub_a), 0);
    q.delete();
    tick();
    tick();
    rst_n = 1;
    #1;
    check("post_rst_ready", 64'(req_ready), 1);
    check("post_rst_valid", 64'(res_valid), 0);
    push(0, 32'd50, 32'd8);
    tick();
    req_valid = 0;
    drain();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
